// File: rtl/hub75_scan.sv
// hub75_scan: raster driver for a 16x32 HUB75 RGB panel. It fetches one
// column at a time from the pattern source, shifts it out, latches the row
// and lights it for DWELL cycles. The screen code is captured once per frame.
// Ports:
//   clk, areset                 clock, async active-low reset
//   screen                      screen code, sampled at frame start
//   pix_top, pix_bot            {R,G,B} for the upper/lower half at the address
//   pix_col, pix_row            pixel address to the pattern source
//   frame_screen, frame_start   code in use this frame, frame start pulse
//   rgb, outclk, lat, oe, abc   panel pins
module hub75_scan #(
    parameter int COLS    = 32,
    parameter int ROWS    = 8,
    parameter int CLK_DIV = 2,
    parameter int DWELL   = 256
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic [5:0]                screen,
    input  logic [2:0]                pix_top,
    input  logic [2:0]                pix_bot,
    output logic [$clog2(COLS)-1:0]   pix_col,
    output logic [$clog2(ROWS)-1:0]   pix_row,
    output logic [5:0]                frame_screen,
    output logic                      frame_start,
    output logic [5:0]                rgb,
    output logic                      outclk,
    output logic                      lat,
    output logic                      oe,
    output logic [$clog2(ROWS)-1:0]   abc
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam int DW = $clog2(DWELL + 1);

    localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DW_LAST  = DW'(DWELL - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        FRAME,
        SHIFT,
        LATCH,
        SHOW
    } state_t;

    state_t        state;
    logic [PW-1:0] ph_cnt;
    logic [DW-1:0] dw_cnt;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state        <= FRAME;
            ph_cnt       <= '0;
            dw_cnt       <= '0;
            pix_col      <= '0;
            pix_row      <= '0;
            frame_screen <= '0;
            frame_start  <= 1'b0;
            rgb          <= '0;
            outclk       <= 1'b0;
            lat          <= 1'b0;
            oe           <= 1'b1;
            abc          <= '0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                FRAME: begin
                    frame_screen <= screen;
                    frame_start  <= 1'b1;
                    pix_row      <= '0;
                    pix_col      <= '0;
                    ph_cnt       <= '0;
                    oe           <= 1'b1;
                    lat          <= 1'b0;
                    outclk       <= 1'b0;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    oe <= 1'b1;
                    // Sample on the first low cycle; the address has been
                    // stable since the column began.
                    if (ph_cnt == '0)
                        rgb <= {pix_top, pix_bot};
                    if (ph_cnt == PH_RISE)
                        outclk <= 1'b1;
                    if (ph_cnt == PH_LAST) begin
                        outclk <= 1'b0;
                        ph_cnt <= '0;
                        if (pix_col == COL_LAST) begin
                            lat   <= 1'b1;
                            state <= LATCH;
                        end else begin
                            pix_col <= pix_col + CW'(1);
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
                LATCH: begin
                    lat    <= 1'b0;
                    outclk <= 1'b0;
                    oe     <= 1'b0;
                    abc    <= pix_row;
                    dw_cnt <= '0;
                    state  <= SHOW;
                end
                SHOW: begin
                    if (dw_cnt == DW_LAST) begin
                        oe      <= 1'b1;
                        pix_col <= '0;
                        dw_cnt  <= '0;
                        if (pix_row == ROW_LAST) begin
                            state <= FRAME;
                        end else begin
                            pix_row <= pix_row + RW'(1);
                            ph_cnt  <= '0;
                            state   <= SHIFT;
                        end
                    end else begin
                        dw_cnt <= dw_cnt + DW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: scoreboard bench for hub75_scan at default parameters plus
// a small COLS=4/ROWS=2/CLK_DIV=1/DWELL=1 instance sharing clock and reset.
module tb_hub75_scan;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic [5:0] screen = 6'd0;

    always #5 clk = ~clk;

    // default instance
    logic [2:0] pix_top, pix_bot, pix_row, abc;
    logic [4:0] pix_col;
    logic [5:0] frame_screen, rgb;
    logic       frame_start, outclk, lat, oe;

    hub75_scan dut (
        .clk(clk), .areset(areset), .screen(screen),
        .pix_top(pix_top), .pix_bot(pix_bot),
        .pix_col(pix_col), .pix_row(pix_row),
        .frame_screen(frame_screen), .frame_start(frame_start),
        .rgb(rgb), .outclk(outclk), .lat(lat), .oe(oe), .abc(abc)
    );

    // pattern source: screen 3 shows column/row codes, others a flat colour
    always_comb begin
        if (frame_screen == 6'd3) begin
            pix_top = pix_col[2:0];
            pix_bot = pix_row;
        end else begin
            pix_top = 3'b100;
            pix_bot = 3'b001;
        end
    end

    // small instance
    logic [2:0] b_top, b_bot;
    logic [1:0] b_col;
    logic [0:0] b_row, b_abc;
    logic [5:0] b_fscr, b_rgb;
    logic       b_fs, b_clk, b_lat, b_oe;

    assign b_top = {1'b0, b_col};
    assign b_bot = {2'b00, b_row};

    hub75_scan #(.COLS(4), .ROWS(2), .CLK_DIV(1), .DWELL(1)) dut_b (
        .clk(clk), .areset(areset), .screen(screen),
        .pix_top(b_top), .pix_bot(b_bot),
        .pix_col(b_col), .pix_row(b_row),
        .frame_screen(b_fscr), .frame_start(b_fs),
        .rgb(b_rgb), .outclk(b_clk), .lat(b_lat), .oe(b_oe), .abc(b_abc)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard queues
    int q_rgb[$];
    int q_abc[$];
    int q_lat[$];
    int q_fs[$];
    int q_gap[$];

    task automatic push_frame(input int scr);
        q_fs.push_back(scr);
        for (int r = 0; r < 8; r++) begin
            q_abc.push_back(r);
            q_lat.push_back(128 + 385 * r);
            for (int c = 0; c < 32; c++)
                q_rgb.push_back(scr == 3 ? (((c % 8) << 3) | r) : 6'b100001);
        end
    endtask

    // monitor for the default instance
    bit         mon_en = 1'b1;
    int         fs_cyc = 0, fs_count = 0, rises = 0, rgb_age = 0, oe_low = 0;
    logic       p_outclk = 1'b0, p_lat = 1'b0, p_oe = 1'b1, p_fs = 1'b0;
    logic [5:0] p_rgb = '0, p_fscr = '0;
    bit         have_prev = 1'b0, stab_err = 1'b0, scr_err = 1'b0;

    always @(negedge clk) begin
        int e;
        if (mon_en && areset) begin
            fs_cyc++;
            rgb_age = (rgb == p_rgb) ? rgb_age + 1 : 1;
            if (outclk && p_outclk && rgb != p_rgb) stab_err = 1'b1;
            if (!frame_start && frame_screen != p_fscr) scr_err = 1'b1;
            if (frame_start) begin
                check("frame_start width", p_fs, 0);
                if (have_prev) begin
                    e = (q_gap.size() != 0) ? q_gap.pop_front() : -1;
                    check("frame period", fs_cyc, e);
                end
                e = (q_fs.size() != 0) ? q_fs.pop_front() : -1;
                check("frame_screen", frame_screen, e);
                check("frame_screen steady", scr_err, 0);
                scr_err   = 1'b0;
                have_prev = 1'b1;
                fs_cyc    = 0;
                fs_count++;
            end
            if (outclk && !p_outclk) begin
                e = (q_rgb.size() != 0) ? q_rgb.pop_front() : -1;
                check("rgb at outclk rise", rgb, e);
                check("oe high in shift", oe, 1);
                check("rgb setup", int'(rgb_age >= 2), 1);
                rises++;
            end
            if (lat) begin
                e = (q_lat.size() != 0) ? q_lat.pop_front() : -1;
                check("lat offset", fs_cyc, e);
                check("outclk rises per row", rises, 32);
                check("oe blank at lat", oe, 1);
                check("rgb stable while outclk high", stab_err, 0);
                rises    = 0;
                stab_err = 1'b0;
            end
            if (p_lat) check("lat one cycle", lat, 0);
            if (!oe && p_oe) begin
                e = (q_abc.size() != 0) ? q_abc.pop_front() : -1;
                check("abc row", abc, e);
                oe_low = 0;
            end
            if (!oe) oe_low++;
            if (oe && !p_oe) check("oe dwell", oe_low, 256);
            p_outclk = outclk;
            p_lat    = lat;
            p_oe     = oe;
            p_fs     = frame_start;
            p_rgb    = rgb;
            p_fscr   = frame_screen;
        end
    end

    // monitor for the small instance
    bit  b_en = 1'b1, b_have = 1'b0, b_err = 1'b0;
    int  b_cyc = 0, b_lats = 0, b_rises = 0;
    logic b_pclk = 1'b0, b_poe = 1'b1;

    always @(negedge clk) begin
        if (!areset) begin
            b_have  = 1'b0;
            b_err   = 1'b0;
            b_rises = 0;
            b_lats  = 0;
            b_pclk  = 1'b0;
            b_poe   = 1'b1;
        end else if (b_en) begin
            b_cyc++;
            if (b_lat && !b_oe) b_err = 1'b1;
            if (b_fs) begin
                if (b_have) check("small frame period", b_cyc, 21);
                check("small oe/lat overlap", b_err, 0);
                b_cyc  = 0;
                b_have = 1'b1;
                b_lats = 0;
                b_err  = 1'b0;
            end
            if (b_clk && !b_pclk) begin
                check("small rgb", b_rgb, (b_rises << 3) | b_lats);
                check("small oe in shift", b_oe, 1);
                b_rises++;
            end
            if (b_lat && b_have) begin
                check("small lat offset", b_cyc, 8 + 10 * b_lats);
                check("small rises per row", b_rises, 4);
                b_lats++;
                b_rises = 0;
            end
            if (!b_oe && b_poe && b_have)
                check("small abc", b_abc, b_lats - 1);
            b_pclk = b_clk;
            b_poe  = b_oe;
        end
    end

    task automatic wait_fs(input int n);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (fs_count >= n) return;
        end
        check("wait frame_start timeout", fs_count, n);
    endtask

    initial begin
        bit hit;
        screen = 6'd16;
        areset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset oe", oe, 1);
        check("reset lat", lat, 0);
        check("reset outclk", outclk, 0);
        check("reset rgb", rgb, 0);
        check("reset abc", abc, 0);
        check("reset frame_start", frame_start, 0);
        check("reset frame_screen", frame_screen, 0);
        check("reset pix_col", pix_col, 0);
        check("reset pix_row", pix_row, 0);

        push_frame(16);
        push_frame(16);
        push_frame(3);
        q_gap.push_back(3081);
        q_gap.push_back(3081);

        #1 areset = 1'b1;
        @(negedge clk);
        #1;
        check("frame_start after release", frame_start, 1);
        check("first frame_screen", frame_screen, 16);
        @(negedge clk);
        #1;
        check("frame_start pulse ends", frame_start, 0);

        // change screen mid-shift in row 4 of frame 2
        wait_fs(2);
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (pix_row == 3'd4 && outclk) hit = 1'b1;
        end
        check("reach row 4 shift", hit, 1);
        screen = 6'd3;
        @(negedge clk);
        #1;
        check("screen held mid-frame", frame_screen, 16);

        wait_fs(3);
        check("screen taken at frame", frame_screen, 3);

        // reset during SHOW of row 5
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (abc == 3'd5 && !oe) hit = 1'b1;
        end
        check("reach row 5 show", hit, 1);
        repeat (20) @(negedge clk);
        #2 areset = 1'b0;
        #1;
        check("async oe", oe, 1);
        check("async lat", lat, 0);
        check("async outclk", outclk, 0);
        check("async abc", abc, 0);
        check("async rgb", rgb, 0);
        check("async pix_row", pix_row, 0);

        q_rgb.delete();
        q_abc.delete();
        q_lat.delete();
        q_fs.delete();
        q_gap.delete();
        have_prev = 1'b0;
        fs_cyc    = 0;
        rises     = 0;
        rgb_age   = 0;
        oe_low    = 0;
        stab_err  = 1'b0;
        scr_err   = 1'b0;
        p_outclk  = 1'b0;
        p_lat     = 1'b0;
        p_oe      = 1'b1;
        p_fs      = 1'b0;
        p_rgb     = '0;
        p_fscr    = '0;

        push_frame(3);
        q_fs.push_back(3);
        q_gap.push_back(3081);

        repeat (2) @(negedge clk);
        #2 areset = 1'b1;
        @(negedge clk);
        #1;
        check("restart frame_start", frame_start, 1);
        check("restart frame_screen", frame_screen, 3);
        check("restart row", pix_row, 0);

        wait_fs(5);
        mon_en = 1'b0;
        b_en   = 1'b0;
        check("scoreboard drained",
              q_rgb.size() + q_abc.size() + q_lat.size() +
              q_fs.size() + q_gap.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
